sdram_pattern_tester: RTL and testbench

Parametrised SDRAM test-pattern engine that drives the write-FIFO and read-FIFO host ports of the SDRAM frame-buffer controller.
- On START: reloads both FIFO address pointers, writes LENGTH words of a selectable pattern, then waits for the write path to drain.
- Reads the words back and compares them against a regenerated pattern.
- Reports pass/fail, a saturating error count and first-error details for the 7-segment and LED status logic.
- Replaces fixed counter-write / key-read demo logic with a self-checking, width- and length-generic engine.

---
 rtl/sdram_pattern_tester.sv | 243 ++++++++++++++++++++++++
 tb/tb_sdram_pattern_tester.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_pattern_tester.sv
// sdram_pattern_tester
// Self-checking test-pattern engine for the SDRAM frame-buffer controller host
// FIFO ports. One run does four things: reload both FIFO address pointers,
// write LENGTH pattern words, let the write path drain, then read the words
// back and compare them with a regenerated copy of the pattern.
//
// Ports
//   REF_CLK, RESET           : clock; synchronous active-high reset
//   START, MODE, SEED, LENGTH: run request; MODE/SEED/LENGTH sampled with START
//   WR_DATA/WR_EN/WR_FULL    : write-FIFO push interface
//   WR_LOAD, RD_LOAD         : FIFO address pointer reloads
//   RD_EN/RD_DATA/RD_EMPTY   : read-FIFO pop interface (RD_DATA valid RD_LAT
//                              cycles after RD_EN)
//   BUSY, DONE, PASS         : run status; DONE/PASS held until the next START
//   ERR_COUNT                : saturating mismatch count
//   FIRST_ERR_IDX/_DATA      : word index and read data of the first mismatch
//
// Build option: define PATTERN_LFSR_EN to build the Galois LFSR pattern
// (MODE 2). Without it, MODE 2 produces the incrementing pattern of MODE 0.
module sdram_pattern_tester #(
  parameter int                DATA_W       = 16,
  parameter int                CNT_W        = 9,
  parameter int                RD_LAT       = 1,
  parameter int                LOAD_CYCLES  = 2,
  parameter int                DRAIN_CYCLES = 64,
  parameter logic [DATA_W-1:0] LFSR_TAPS    = DATA_W'(16'hB400)
) (
  input  logic              REF_CLK,
  input  logic              RESET,
  input  logic              START,
  input  logic [1:0]        MODE,
  input  logic [DATA_W-1:0] SEED,
  input  logic [CNT_W-1:0]  LENGTH,
  output logic [DATA_W-1:0] WR_DATA,
  output logic              WR_EN,
  input  logic              WR_FULL,
  output logic              WR_LOAD,
  output logic              RD_EN,
  input  logic [DATA_W-1:0] RD_DATA,
  input  logic              RD_EMPTY,
  output logic              RD_LOAD,
  output logic              BUSY,
  output logic              DONE,
  output logic              PASS,
  output logic [CNT_W-1:0]  ERR_COUNT,
  output logic [CNT_W-1:0]  FIRST_ERR_IDX,
  output logic [DATA_W-1:0] FIRST_ERR_DATA
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WRITE, S_DRAIN, S_READ, S_DONE} state_t;
  typedef enum logic [1:0] {M_INC, M_WALK, M_LFSR, M_AINV} mode_t;

  localparam int TMR_MAX = (DRAIN_CYCLES > LOAD_CYCLES) ? DRAIN_CYCLES : LOAD_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  // First word of a pattern (word index 0).
  function automatic logic [DATA_W-1:0] pat_first(input mode_t mode,
                                                   input logic [DATA_W-1:0] seed);
    logic [DATA_W-1:0] w;
    case (mode)
      M_WALK:  w = DATA_W'(1);
`ifdef PATTERN_LFSR_EN
      M_LFSR:  w = (seed == '0) ? DATA_W'(1) : seed;  // all-zero state would lock up
`endif
      M_AINV:  w = '1;                                 // ~0
      default: w = seed;
    endcase
    return w;
  endfunction

  // Word i+1 from word i. AINV counts down because ~(i+1) == ~i - 1.
  function automatic logic [DATA_W-1:0] pat_next(input mode_t mode,
                                                  input logic [DATA_W-1:0] w);
    logic [DATA_W-1:0] n;
    case (mode)
      M_WALK:  n = {w[DATA_W-2:0], w[DATA_W-1]};
`ifdef PATTERN_LFSR_EN
      M_LFSR:  n = (w >> 1) ^ (w[0] ? LFSR_TAPS : '0);
`endif
      M_AINV:  n = w - DATA_W'(1);
      default: n = w + DATA_W'(1);
    endcase
    return n;
  endfunction

  state_t             state_q, state_d;
  mode_t              mode_q, mode_d;
  logic [CNT_W-1:0]   len_q, len_d;
  logic [CNT_W-1:0]   wr_idx_q, wr_idx_d;
  logic [CNT_W-1:0]   rd_issued_q, rd_issued_d;
  logic [CNT_W-1:0]   rd_checked_q, rd_checked_d;
  logic [DATA_W-1:0]  wr_word_q, wr_word_d;
  logic [DATA_W-1:0]  rd_word_q, rd_word_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [RD_LAT-1:0]  rd_vld_q, rd_vld_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  logic [CNT_W-1:0]   err_q, err_d;
  logic [CNT_W-1:0]   first_idx_q, first_idx_d;
  logic [DATA_W-1:0]  first_data_q, first_data_d;
  logic               start_ok;
  logic               rd_check;

  assign start_ok = (state_q == S_IDLE) && START;
  assign rd_check = rd_vld_q[RD_LAT-1];   // read word emerging from the latency pipe

  // State register and all datapath flops.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge REF_CLK) begin
    if (RESET) begin
      state_q      <= S_IDLE;
      mode_q       <= M_INC;
      len_q        <= '0;
      wr_idx_q     <= '0;
      rd_issued_q  <= '0;
      rd_checked_q <= '0;
      wr_word_q    <= '0;
      rd_word_q    <= '0;
      tmr_q        <= '0;
      rd_vld_q     <= '0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      err_q        <= '0;
      first_idx_q  <= '0;
      first_data_q <= '0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      len_q        <= len_d;
      wr_idx_q     <= wr_idx_d;
      rd_issued_q  <= rd_issued_d;
      rd_checked_q <= rd_checked_d;
      wr_word_q    <= wr_word_d;
      rd_word_q    <= rd_word_d;
      tmr_q        <= tmr_d;
      rd_vld_q     <= rd_vld_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      err_q        <= err_d;
      first_idx_q  <= first_idx_d;
      first_data_q <= first_data_d;
    end
  end

  // Next-state logic.
  // NOTE: every combinational output gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (START) state_d = (LENGTH == '0) ? S_DONE : S_LOAD;
      S_LOAD:  if (tmr_q == TMR_W'(LOAD_CYCLES - 1)) state_d = S_WRITE;
      S_WRITE: if (wr_idx_q == len_q) state_d = S_DRAIN;
      S_DRAIN: if (tmr_q == TMR_W'(DRAIN_CYCLES - 1)) state_d = S_READ;
      S_READ:  if (rd_checked_q == len_q) state_d = S_DONE;
      default: state_d = S_IDLE;   // S_DONE lasts one cycle; status stays in flops
    endcase
  end

  // Output logic.
  always_comb begin
    BUSY    = 1'b0;
    WR_EN   = 1'b0;
    RD_EN   = 1'b0;
    WR_LOAD = 1'b0;
    RD_LOAD = 1'b0;
    case (state_q)
      S_LOAD:  begin BUSY = 1'b1; WR_LOAD = 1'b1; RD_LOAD = 1'b1; end
      S_WRITE: begin BUSY = 1'b1; WR_EN = !WR_FULL && (wr_idx_q < len_q); end
      S_DRAIN: begin BUSY = 1'b1; RD_LOAD = 1'b1; end    // flushes stale prefetch
      S_READ:  begin BUSY = 1'b1; RD_EN = !RD_EMPTY && (rd_issued_q < len_q); end
      default: ;
    endcase
  end

  // Datapath: counters, pattern generators, compare and error capture.
  always_comb begin
    mode_d       = mode_q;
    len_d        = len_q;
    wr_idx_d     = wr_idx_q;
    rd_issued_d  = rd_issued_q;
    rd_checked_d = rd_checked_q;
    wr_word_d    = wr_word_q;
    rd_word_d    = rd_word_q;
    done_d       = done_q;
    pass_d       = pass_q;
    err_d        = err_q;
    first_idx_d  = first_idx_q;
    first_data_d = first_data_q;
    tmr_d        = ((state_d == state_q) && (state_q == S_LOAD || state_q == S_DRAIN))
                   ? tmr_q + TMR_W'(1) : '0;
    rd_vld_d     = (rd_vld_q << 1) | RD_LAT'(RD_EN);

    if (start_ok) begin
      mode_d       = mode_t'(MODE);
      len_d        = LENGTH;
      wr_idx_d     = '0;
      rd_issued_d  = '0;
      rd_checked_d = '0;
      wr_word_d    = pat_first(mode_t'(MODE), SEED);
      rd_word_d    = pat_first(mode_t'(MODE), SEED);
      rd_vld_d     = '0;
      err_d        = '0;
      first_idx_d  = '0;
      first_data_d = '0;
      done_d       = (LENGTH == '0);   // empty run completes immediately, passing
      pass_d       = (LENGTH == '0);
    end

    if (WR_EN) begin
      wr_idx_d  = wr_idx_q + CNT_W'(1);
      wr_word_d = pat_next(mode_q, wr_word_q);
    end

    if (RD_EN) rd_issued_d = rd_issued_q + CNT_W'(1);

    if (rd_check) begin
      rd_checked_d = rd_checked_q + CNT_W'(1);
      rd_word_d    = pat_next(mode_q, rd_word_q);
      if (RD_DATA != rd_word_q) begin
        if (err_q != '1) err_d = err_q + CNT_W'(1);
        if (err_q == '0) begin           // count never returns to 0, so this is the first
          first_idx_d  = rd_checked_q;
          first_data_d = RD_DATA;
        end
      end
    end

    if (state_q == S_READ && state_d == S_DONE) begin
      done_d = 1'b1;
      pass_d = (err_q == '0);
    end
  end

  assign WR_DATA        = wr_word_q;
  assign DONE           = done_q;
  assign PASS           = pass_q;
  assign ERR_COUNT      = err_q;
  assign FIRST_ERR_IDX  = first_idx_q;
  assign FIRST_ERR_DATA = first_data_q;

endmodule

// File: tb/tb_sdram_pattern_tester.sv
// Testbench for sdram_pattern_tester: an ideal FIFO/memory model with optional
// read-data corruption, a write scoreboard and a table of test runs plus
// hand-written sequences for empty runs, reset mid-write and START while busy.
module tb_sdram_pattern_tester;
  localparam int DW = 16;
  localparam int CW = 9;

  logic          REF_CLK = 1'b0;
  logic          RESET, START, WR_FULL, RD_EMPTY;
  logic [1:0]    MODE;
  logic [DW-1:0] SEED, RD_DATA;
  logic [CW-1:0] LENGTH;
  logic [DW-1:0] WR_DATA, FIRST_ERR_DATA;
  logic          WR_EN, WR_LOAD, RD_EN, RD_LOAD, BUSY, DONE, PASS;
  logic [CW-1:0] ERR_COUNT, FIRST_ERR_IDX;

  sdram_pattern_tester dut (
    .REF_CLK(REF_CLK), .RESET(RESET), .START(START), .MODE(MODE), .SEED(SEED),
    .LENGTH(LENGTH), .WR_DATA(WR_DATA), .WR_EN(WR_EN), .WR_FULL(WR_FULL),
    .WR_LOAD(WR_LOAD), .RD_EN(RD_EN), .RD_DATA(RD_DATA), .RD_EMPTY(RD_EMPTY),
    .RD_LOAD(RD_LOAD), .BUSY(BUSY), .DONE(DONE), .PASS(PASS),
    .ERR_COUNT(ERR_COUNT), .FIRST_ERR_IDX(FIRST_ERR_IDX),
    .FIRST_ERR_DATA(FIRST_ERR_DATA)
  );

  always #5 REF_CLK = ~REF_CLK;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] mem[$];        // words pushed into the write FIFO, in order
  logic [DW-1:0] exp_wr_q[$];   // scoreboard of expected write words
  int            rd_ptr   = 0;
  int            flip_idx = -1; // word index whose bit 0 is flipped on read
  bit            flip_all = 1'b0;
  int            wr_cnt   = 0;
  int            rd_cnt   = 0;

  typedef struct {
    logic [1:0]    mode;
    logic [DW-1:0] seed;
    int            len;
    int            flip;
    bit            flip_all;
    bit            gaps;
    bit            exp_pass;
    int            exp_err;
    int            exp_idx;
    logic [DW-1:0] exp_data;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference pattern, computed directly from the word index.
  function automatic logic [DW-1:0] gen_word(input logic [1:0] m, input logic [DW-1:0] s,
                                             input int i);
    case (m)
      2'd0: return s + DW'(i);
      2'd1: return DW'(1) << (i % DW);
      2'd2: begin
`ifdef PATTERN_LFSR_EN
        logic [DW-1:0] st;
        st = (s == '0) ? DW'(1) : s;
        for (int k = 0; k < i; k++) st = st[0] ? ((st >> 1) ^ 16'hB400) : (st >> 1);
        return st;
`else
        return s + DW'(i);
`endif
      end
      default: return ~DW'(i);
    endcase
  endfunction

  // Ideal FIFO/memory model: RD_DATA valid one cycle after RD_EN.
  always @(posedge REF_CLK) begin
    if (RESET) begin
      rd_ptr = 0;
      RD_DATA <= '0;
    end else begin
      if (WR_EN) mem.push_back(WR_DATA);
      if (RD_LOAD) rd_ptr = 0;
      else if (RD_EN) begin
        RD_DATA <= ((rd_ptr < mem.size()) ? mem[rd_ptr] : 16'hDEAD) ^
                   DW'((flip_all || rd_ptr == flip_idx) ? 1 : 0);
        rd_ptr++;
      end
    end
  end

  // Monitor, sampled mid-cycle: write scoreboard and flow-control rules.
  always @(negedge REF_CLK) begin
    if (!RESET) begin
      if (WR_EN) begin
        wr_cnt++;
        check("no_push_while_full", WR_FULL, 0);
        check("write_expected", exp_wr_q.size() > 0, 1);
        if (exp_wr_q.size() > 0) check("wr_data", WR_DATA, exp_wr_q.pop_front());
      end
      if (RD_EN) rd_cnt++;
      if (RD_EMPTY) check("no_pop_while_empty", RD_EN, 0);
    end
  end

  task automatic prep(input logic [1:0] m, input logic [DW-1:0] s, input int len);
    mem.delete();
    exp_wr_q.delete();
    wr_cnt = 0;
    rd_cnt = 0;
    for (int i = 0; i < len; i++) exp_wr_q.push_back(gen_word(m, s, i));
  endtask

  task automatic start_run(input logic [1:0] m, input logic [DW-1:0] s, input int len);
    @(posedge REF_CLK); #1;
    START = 1'b1; MODE = m; SEED = s; LENGTH = CW'(len);
    @(posedge REF_CLK); #1;
    START = 1'b0;
  endtask

  // Full run: optional FIFO gaps and an ignored START pulse while busy.
  task automatic run_vec(input vec_t v, input string tag, input bit busy_start);
    int  full_cyc  = 0;
    int  cyc       = 0;
    bit  done_seen = 1'b0;
    prep(v.mode, v.seed, v.len);
    flip_idx = v.flip;
    flip_all = v.flip_all;
    start_run(v.mode, v.seed, v.len);
    check({tag, "_busy_after_start"}, BUSY, 1);
    check({tag, "_done_cleared"}, DONE, 0);
    while (cyc < 3000) begin
      @(posedge REF_CLK); #1;
      cyc++;
      if (DONE) begin done_seen = 1'b1; break; end
      if (busy_start) begin
        START  = (cyc == 3);
        MODE   = 2'd3; SEED = 16'hFFFF; LENGTH = CW'(2);
      end
      if (v.gaps) begin
        if (wr_cnt >= v.len / 2 && full_cyc < 10) begin
          WR_FULL = 1'b1;
          full_cyc++;
        end else WR_FULL = 1'b0;
        RD_EMPTY = (rd_cnt >= 2 && rd_cnt < v.len - 2 && cyc % 3 != 0) ? 1'b1 : 1'b0;
      end
    end
    START = 1'b0; WR_FULL = 1'b0; RD_EMPTY = 1'b0;
    check({tag, "_done_in_time"}, done_seen, 1);
    check({tag, "_pass"}, PASS, v.exp_pass);
    check({tag, "_err_count"}, ERR_COUNT, v.exp_err);
    check({tag, "_first_err_idx"}, FIRST_ERR_IDX, v.exp_idx);
    check({tag, "_first_err_data"}, FIRST_ERR_DATA, v.exp_data);
    check({tag, "_busy_low"}, BUSY, 0);
    check({tag, "_write_count"}, wr_cnt, v.len);
    check({tag, "_read_count"}, rd_cnt, v.len);
    check({tag, "_all_writes_seen"}, exp_wr_q.size(), 0);
    if (v.gaps) check({tag, "_full_gap_cycles"}, full_cyc, 10);
    repeat (3) @(posedge REF_CLK);
    #1;
    check({tag, "_done_held"}, DONE, 1);
    flip_idx = -1;
    flip_all = 1'b0;
  endtask

  vec_t vecs[6];
  vec_t v;
  int   waited;

  initial begin
    //        mode  seed      len flip all gaps pass err idx data
    vecs[0] = '{2'd0, 16'h0010,  4, -1, 0, 0, 1,  0, 0, 16'h0000};
    vecs[1] = '{2'd1, 16'hABCD, 18, -1, 0, 0, 1,  0, 0, 16'h0000};
    vecs[2] = '{2'd3, 16'h0000,  8,  5, 0, 0, 0,  1, 5, 16'hFFFB};
    vecs[3] = '{2'd0, 16'hFFFE, 16, -1, 0, 1, 1,  0, 0, 16'h0000};
    vecs[4] = '{2'd2, 16'h1234, 10, -1, 0, 0, 1,  0, 0, 16'h0000};
    vecs[5] = '{2'd0, 16'h0000, 20, -1, 1, 0, 0, 20, 0, 16'h0001};

    RESET = 1'b1; START = 1'b0; MODE = '0; SEED = '0; LENGTH = '0;
    WR_FULL = 1'b0; RD_EMPTY = 1'b0;
    repeat (3) @(posedge REF_CLK);
    #1;
    check("rst_busy", BUSY, 0);
    check("rst_done", DONE, 0);
    check("rst_pass", PASS, 0);
    check("rst_wr_en", WR_EN, 0);
    check("rst_loads", {WR_LOAD, RD_LOAD, RD_EN}, 0);
    check("rst_err", ERR_COUNT, 0);
    check("rst_wr_data", WR_DATA, 0);
    RESET = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i), 1'b0);

    // LFSR from a zero seed: the first two words written.
    v = '{2'd2, 16'h0000, 2, -1, 0, 0, 1, 0, 0, 16'h0000};
    run_vec(v, "lfsr_seed0", 1'b0);
    check("lfsr_mem_size", mem.size(), 2);
    if (mem.size() >= 2) begin
`ifdef PATTERN_LFSR_EN
      check("lfsr_word0", mem[0], 16'h0001);
      check("lfsr_word1", mem[1], 16'hB400);
`else
      check("lfsr_word0", mem[0], 16'h0000);
      check("lfsr_word1", mem[1], 16'h0001);
`endif
    end

    // LENGTH == 0: DONE/PASS right after the START edge, no FIFO activity.
    prep(2'd0, 16'h0005, 0);
    start_run(2'd0, 16'h0005, 0);
    check("len0_done", DONE, 1);
    check("len0_pass", PASS, 1);
    check("len0_busy", BUSY, 0);
    check("len0_no_load", WR_LOAD, 0);
    repeat (5) @(posedge REF_CLK);
    #1;
    check("len0_no_writes", wr_cnt, 0);
    check("len0_done_held", DONE, 1);

    // START while busy is ignored: the run completes with the first parameters.
    v = '{2'd0, 16'h0100, 6, -1, 0, 0, 1, 0, 0, 16'h0000};
    run_vec(v, "busy_start", 1'b1);

    // RESET mid-write aborts the run on the next edge.
    prep(2'd0, 16'h0040, 32);
    start_run(2'd0, 16'h0040, 32);
    waited = 0;
    while (wr_cnt < 3 && waited < 200) begin
      @(posedge REF_CLK); #1;
      waited++;
    end
    check("rst_mid_reached_write", wr_cnt >= 3, 1);
    RESET = 1'b1;
    @(posedge REF_CLK); #1;
    check("rst_mid_busy", BUSY, 0);
    check("rst_mid_wr_en", WR_EN, 0);
    check("rst_mid_done", DONE, 0);
    check("rst_mid_wr_data", WR_DATA, 0);
    check("rst_mid_loads", {WR_LOAD, RD_LOAD, RD_EN}, 0);
    RESET = 1'b0;
    exp_wr_q.delete();

    // A normal run after the abort.
    run_vec(vecs[0], "after_reset", 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
